// File: rtl/vpu_fp_dst_port.sv
// Destination-port stage for VPU float ALU results: buffers accepted results in a small FIFO
// and drains them to the SRAM write port at consecutive addresses, reporting busy/done per job.
module vpu_fp_dst_port #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic              result_valid_i,
    output logic              result_ready_o,
    output logic              sram_w_req_o,
    output logic [ADDR_W-1:0] sram_w_addr_o,
    output logic [DATA_W-1:0] sram_w_data_o,
    input  logic              sram_w_gnt_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]    count_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q, acc_cnt_q, wr_cnt_q;

    logic active, fifo_full, fifo_empty, push, pop, last_write;

    assign active     = (state_q == S_ACTIVE);
    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Ready depends only on registered state, never on valid or grant.
    assign result_ready_o = active && !fifo_full && (acc_cnt_q < len_q);
    assign sram_w_req_o   = active && !fifo_empty;
    assign sram_w_addr_o  = sram_w_req_o ? base_q + ADDR_W'(wr_cnt_q) : '0;
    assign sram_w_data_o  = sram_w_req_o ? mem[rd_ptr_q] : '0;
    assign busy_o         = active;
    assign done_o         = (state_q == S_DONE);

    assign push       = result_valid_i && result_ready_o;
    assign pop        = sram_w_req_o && sram_w_gnt_i;
    assign last_write = pop && (({1'b0, wr_cnt_q} + (LEN_W+1)'(1)) == {1'b0, len_q});

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = (len_i == '0) ? S_DONE : S_ACTIVE;
            S_ACTIVE: if (last_write) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            base_q    <= '0;
            len_q     <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start_i) begin
                base_q    <= base_addr_i;
                len_q     <= len_i;
                acc_cnt_q <= '0;
                wr_cnt_q  <= '0;
            end else begin
                if (push) acc_cnt_q <= acc_cnt_q + 1'b1;
                if (pop)  wr_cnt_q  <= wr_cnt_q + 1'b1;
            end
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and count define validity, so reset empties it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= result_i;
    end

endmodule

// File: tb/tb_vpu_fp_dst_port.sv
// Randomized bench for vpu_fp_dst_port against a queue-based job model.
module tb_vpu_fp_dst_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [9:0]  base_addr_i;
    logic [9:0]  len_i;
    logic [15:0] result_i;
    logic        result_valid_i;
    logic        result_ready_o;
    logic        sram_w_req_o;
    logic [9:0]  sram_w_addr_o;
    logic [15:0] sram_w_data_o;
    logic        sram_w_gnt_i;
    logic        busy_o;
    logic        done_o;

    int passed = 0;
    int total  = 0;

    // Reference model: job phase, counters and a queue of accepted results.
    int          m_state = 0;   // 0 idle, 1 running, 2 finished
    int          m_base  = 0;
    int          m_len   = 0;
    int          m_acc   = 0;
    int          m_wr    = 0;
    logic [15:0] q[$];

    localparam int BUDGET = 2000;

    vpu_fp_dst_port dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .len_i          (len_i),
        .result_i       (result_i),
        .result_valid_i (result_valid_i),
        .result_ready_o (result_ready_o),
        .sram_w_req_o   (sram_w_req_o),
        .sram_w_addr_o  (sram_w_addr_o),
        .sram_w_data_o  (sram_w_data_o),
        .sram_w_gnt_i   (sram_w_gnt_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else passed++;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic step(input logic r, input logic s, input logic [9:0] b, input logic [9:0] l,
                        input logic v, input logic [15:0] d, input logic g);
        logic        exp_ready, exp_req;
        logic [9:0]  exp_addr;
        logic [15:0] exp_data;
        @(negedge clk);
        rst_n = r; start_i = s; base_addr_i = b; len_i = l;
        result_valid_i = v; result_i = d; sram_w_gnt_i = g;
        #1;
        exp_ready = (m_state == 1) && (q.size() < 4) && (m_acc < m_len);
        exp_req   = (m_state == 1) && (q.size() > 0);
        exp_addr  = exp_req ? 10'((m_base + m_wr) % 1024) : 10'd0;
        exp_data  = exp_req ? q[0] : 16'd0;
        check("ready", 32'(result_ready_o), 32'(exp_ready));
        check("req",   32'(sram_w_req_o),   32'(exp_req));
        check("addr",  32'(sram_w_addr_o),  32'(exp_addr));
        check("data",  32'(sram_w_data_o),  32'(exp_data));
        check("busy",  32'(busy_o),         32'(m_state == 1));
        check("done",  32'(done_o),         32'(m_state == 2));
        if (!r) begin
            m_state = 0; m_acc = 0; m_wr = 0;
            q.delete();
        end else begin
            case (m_state)
                0: if (s) begin
                    m_base = int'(b); m_len = int'(l); m_acc = 0; m_wr = 0;
                    m_state = (l == 10'd0) ? 2 : 1;
                end
                1: begin
                    if (exp_req && g) begin
                        void'(q.pop_front());
                        m_wr++;
                        if (m_wr == m_len) m_state = 2;
                    end
                    if (v && exp_ready) begin
                        q.push_back(d);
                        m_acc++;
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic run_job(input logic [9:0] base, input logic [9:0] len, input int vpct,
                           input int gpct, input int gnt_off, input int abort_at, input int spct);
        int   cyc;
        logic v, g, s, r;
        step(1'b1, 1'b1, base, len, 1'b1, 16'($urandom), 1'b1);
        cyc = 0;
        while (m_state != 0 && cyc < BUDGET) begin
            v = ($urandom_range(99) < 32'(vpct));
            g = (cyc < gnt_off) ? 1'b0 : ($urandom_range(99) < 32'(gpct));
            s = ($urandom_range(99) < 32'(spct));
            r = !(abort_at > 0 && cyc == abort_at);
            step(r, s, 10'($urandom), 10'($urandom), v, 16'($urandom), g);
            cyc++;
        end
        check("job_bounded", 32'(cyc < BUDGET), 32'd1);
        // An idle cycle offering a result must not be accepted.
        step(1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 16'($urandom), 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0;
        result_i = '0; result_valid_i = 1'b0; sram_w_gnt_i = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held with valid and grant asserted.
        repeat (3) step(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 16'hBEEF, 1'b1);

        run_job(10'h010, 10'd4, 100, 100, 0, 0, 0);    // back-to-back, full throughput
        run_job(10'h080, 10'd8, 100, 100, 10, 0, 0);   // grant stalled, FIFO fills
        run_job(10'h3FE, 10'd4, 100, 100, 0, 0, 0);    // address wrap
        run_job(10'h123, 10'd0, 100, 100, 0, 0, 0);    // zero-length job
        run_job(10'h100, 10'd6, 100, 50, 0, 0, 40);    // start pulses while busy
        run_job(10'h020, 10'd3, 100, 100, 6, 0, 0);    // surplus results refused
        run_job(10'h040, 10'd8, 100, 100, 4, 5, 0);    // reset mid-job

        for (int i = 0; i < 20; i++)
            run_job(10'($urandom), 10'($urandom_range(12)), int'($urandom_range(30, 100)),
                    int'($urandom_range(20, 100)), int'($urandom_range(0, 6)), 0, 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
